// File: rtl/sat_corr.sv
// sat_corr: carrier wipe-off and C/A despreading correlator with integrate-and-dump output.
// Three-stage pipeline (capture, rotate/despread, accumulate) with gapless back-to-back dumps.
module sat_corr (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [15:0] real_in,
   input  logic [15:0] imag_in,
   input  logic [31:0] freq,
   input  logic [5:0]  ca_sel,
   input  logic [35:0] ca_seq,
   input  logic [15:0] dump_len,
   input  logic        start,
   input  logic        stop,
   output logic        busy,
   output logic        result_valid,
   input  logic        result_ready,
   output logic [31:0] acc_real,
   output logic [31:0] acc_imag,
   output logic [7:0]  result_seq,
   output logic        overrun
);

   typedef enum logic [0:0] {StIdle, StInteg} state_e;

   state_e      state_q, state_d;
   logic [15:0] len_q, len_d, cnt_q, cnt_d;
   logic [31:0] phase_q, phase_d;

   logic        s1_vld_q, s1_vld_d, s1_last_q, s1_last_d, s1_neg_q, s1_neg_d;
   logic [1:0]  s1_quad_q, s1_quad_d;
   logic [15:0] s1_re_q, s1_re_d, s1_im_q, s1_im_d;

   logic        s2_vld_q, s2_vld_d, s2_last_q, s2_last_d;
   logic [15:0] s2_re_q, s2_re_d, s2_im_q, s2_im_d;

   logic [31:0] acc_re_q, acc_re_d, acc_im_q, acc_im_d;
   logic [31:0] res_re_q, res_re_d, res_im_q, res_im_d;
   logic        res_vld_q, res_vld_d, ovr_q, ovr_d;
   logic [7:0]  seq_q, seq_d;

   logic        accept, kill;
   logic [15:0] cnt_inc, rot_re, rot_im;
   logic [31:0] sum_re, sum_im;

   // Two's-complement negation that maps the most negative value to the most positive.
   function automatic logic [15:0] sat_neg(input logic [15:0] x);
      return (x == 16'h8000) ? 16'h7fff : (16'h0000 - x);
   endfunction

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      cnt_d     = cnt_q;
      phase_d   = phase_q;
      s1_vld_d  = s1_vld_q;
      s1_last_d = s1_last_q;
      s1_neg_d  = s1_neg_q;
      s1_quad_d = s1_quad_q;
      s1_re_d   = s1_re_q;
      s1_im_d   = s1_im_q;
      s2_vld_d  = s2_vld_q;
      s2_last_d = s2_last_q;
      s2_re_d   = s2_re_q;
      s2_im_d   = s2_im_q;
      acc_re_d  = acc_re_q;
      acc_im_d  = acc_im_q;
      res_re_d  = res_re_q;
      res_im_d  = res_im_q;
      res_vld_d = res_vld_q;
      ovr_d     = ovr_q;
      seq_d     = seq_q;
      rot_re    = s1_re_q;
      rot_im    = s1_im_q;

      kill    = (state_q == StInteg) && stop;
      accept  = (state_q == StInteg) && enable && !stop;
      cnt_inc = cnt_q + 16'd1;
      sum_re  = acc_re_q + {{16{s2_re_q[15]}}, s2_re_q};
      sum_im  = acc_im_q + {{16{s2_im_q[15]}}, s2_im_q};

      // Stage 1: capture sample, code bit and pre-increment quadrant.
      s1_vld_d = accept;
      if (accept) begin
         s1_re_d   = real_in;
         s1_im_d   = imag_in;
         s1_quad_d = phase_q[31:30];
         s1_neg_d  = (ca_sel < 6'd36) ? ca_seq[ca_sel] : 1'b0;
         s1_last_d = (cnt_inc == len_q);
         cnt_d     = (cnt_inc == len_q) ? 16'd0 : cnt_inc;
         phase_d   = phase_q + freq;
      end

      // Stage 2: quadrant rotation then despreading.
      case (s1_quad_q)
         2'd0: begin
            rot_re = s1_re_q;
            rot_im = s1_im_q;
         end
         2'd1: begin
            rot_re = s1_im_q;
            rot_im = sat_neg(s1_re_q);
         end
         2'd2: begin
            rot_re = sat_neg(s1_re_q);
            rot_im = sat_neg(s1_im_q);
         end
         default: begin
            rot_re = sat_neg(s1_im_q);
            rot_im = s1_re_q;
         end
      endcase
      s2_vld_d = s1_vld_q && !kill;
      if (s1_vld_q) begin
         s2_last_d = s1_last_q;
         s2_re_d   = s1_neg_q ? sat_neg(rot_re) : rot_re;
         s2_im_d   = s1_neg_q ? sat_neg(rot_im) : rot_im;
      end

      // Stage 3: accumulate, and on a tagged sample dump into the result registers.
      if (res_vld_q && result_ready) begin
         res_vld_d = 1'b0;
      end
      if (s2_vld_q && !kill) begin
         if (s2_last_q) begin
            res_re_d  = sum_re;
            res_im_d  = sum_im;
            acc_re_d  = 32'd0;
            acc_im_d  = 32'd0;
            seq_d     = seq_q + 8'd1;
            res_vld_d = 1'b1;
            if (res_vld_q && !result_ready) begin
               ovr_d = 1'b1;
            end
         end else begin
            acc_re_d = sum_re;
            acc_im_d = sum_im;
         end
      end

      if (kill) begin
         state_d  = StIdle;
         acc_re_d = 32'd0;
         acc_im_d = 32'd0;
      end
      if ((state_q == StIdle) && start && (dump_len != 16'd0)) begin
         state_d  = StInteg;
         len_d    = dump_len;
         phase_d  = 32'd0;
         cnt_d    = 16'd0;
         acc_re_d = 32'd0;
         acc_im_d = 32'd0;
         ovr_d    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         len_q     <= 16'd0;
         cnt_q     <= 16'd0;
         phase_q   <= 32'd0;
         s1_vld_q  <= 1'b0;
         s1_last_q <= 1'b0;
         s1_neg_q  <= 1'b0;
         s1_quad_q <= 2'd0;
         s1_re_q   <= 16'd0;
         s1_im_q   <= 16'd0;
         s2_vld_q  <= 1'b0;
         s2_last_q <= 1'b0;
         s2_re_q   <= 16'd0;
         s2_im_q   <= 16'd0;
         acc_re_q  <= 32'd0;
         acc_im_q  <= 32'd0;
         res_re_q  <= 32'd0;
         res_im_q  <= 32'd0;
         res_vld_q <= 1'b0;
         ovr_q     <= 1'b0;
         seq_q     <= 8'd0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         cnt_q     <= cnt_d;
         phase_q   <= phase_d;
         s1_vld_q  <= s1_vld_d;
         s1_last_q <= s1_last_d;
         s1_neg_q  <= s1_neg_d;
         s1_quad_q <= s1_quad_d;
         s1_re_q   <= s1_re_d;
         s1_im_q   <= s1_im_d;
         s2_vld_q  <= s2_vld_d;
         s2_last_q <= s2_last_d;
         s2_re_q   <= s2_re_d;
         s2_im_q   <= s2_im_d;
         acc_re_q  <= acc_re_d;
         acc_im_q  <= acc_im_d;
         res_re_q  <= res_re_d;
         res_im_q  <= res_im_d;
         res_vld_q <= res_vld_d;
         ovr_q     <= ovr_d;
         seq_q     <= seq_d;
      end
   end

   assign busy         = (state_q == StInteg);
   assign result_valid = res_vld_q;
   assign acc_real     = res_re_q;
   assign acc_imag     = res_im_q;
   assign result_seq   = seq_q;
   assign overrun      = ovr_q;

endmodule
